vga_sync_decoder: RTL and testbench

Receive-side counterpart to display_controller. It samples hSync, vSync and bright on pixel strobes and rebuilds hCount/vCount from the sync edges alone. It checks line length, frame length, sync widths and the active window against 640x480 timing, and reports lock and error status. It sits beside display_controller in on-board self-check builds, with its error count routed to the SSDs.

---
 rtl/vga_sync_decoder.sv | 192 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side 640x480 timing checker: rebuilds pixel/line counters from
// the sync edges and reports lock, per-sample violations and an error total.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_SYNC      = 96,
    parameter int V_SYNC      = 2,
    parameter int H_ACT_START = 144,
    parameter int H_ACT       = 640,
    parameter int V_ACT_START = 35,
    parameter int V_ACT       = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       hSync,
    input  logic       vSync,
    input  logic       bright,
    output logic [9:0] hCount_rx,
    output logic [9:0] vCount_rx,
    output logic       locked,
    output logic       frame_done,
    output logic       err,
    output logic [7:0] err_count,
    output logic [1:0] state
);

    localparam logic [1:0] S_SEARCH = 2'b00;
    localparam logic [1:0] S_TRACK  = 2'b01;
    localparam logic [1:0] S_LOCKED = 2'b10;

    localparam logic [9:0] CNT_MAX = 10'h3FF;
    localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
    localparam logic [9:0] HSW = 10'(H_SYNC);
    localparam logic [9:0] VSW = 10'(V_SYNC);
    localparam logic [9:0] HA0 = 10'(H_ACT_START);
    localparam logic [9:0] HA1 = 10'(H_ACT_START + H_ACT - 1);
    localparam logic [9:0] VA0 = 10'(V_ACT_START);
    localparam logic [9:0] VA1 = 10'(V_ACT_START + V_ACT - 1);
    localparam logic [7:0] LF  = 8'(LOCK_FRAMES);

    logic       h_prev_q, h_prev_d, v_prev_q, v_prev_d;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0] hlow_q, hlow_d, vlow_q, vlow_d;
    logic [7:0] good_q, good_d, errcnt_q, errcnt_d;
    logic [1:0] state_q, state_d;
    logic       ferr_q, ferr_d, locked_q, locked_d;
    logic       err_q, err_d, fdone_q, fdone_d;

    logic       hfall, hrise, vfall, vrise, in_win, viol;
    logic [9:0] hcnt_nx, vcnt_nx, hlow_nx, vlow_nx;

    assign hfall = h_prev_q & ~hSync;
    assign hrise = ~h_prev_q & hSync;
    assign vfall = v_prev_q & ~vSync;
    assign vrise = ~v_prev_q & vSync;

    always_comb begin
        hcnt_nx = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
        if (hfall) hcnt_nx = '0;
        vcnt_nx = vcnt_q;
        if (vfall) vcnt_nx = '0;
        else if (hfall && vcnt_q != CNT_MAX) vcnt_nx = vcnt_q + 10'd1;
        hlow_nx = '0;
        if (hfall) hlow_nx = 10'd1;
        else if (!hSync) hlow_nx = (hlow_q == CNT_MAX) ? hlow_q : hlow_q + 10'd1;
        // vSync width is measured in lines, so only hfalls advance it
        vlow_nx = '0;
        if (vfall) vlow_nx = 10'd1;
        else if (!vSync && hfall && vlow_q != CNT_MAX) vlow_nx = vlow_q + 10'd1;
        else if (!vSync) vlow_nx = vlow_q;
        in_win = (hcnt_nx >= HA0) && (hcnt_nx <= HA1) &&
                 (vcnt_nx >= VA0) && (vcnt_nx <= VA1);
        viol = (state_q != S_SEARCH) &&
               ((hfall && hcnt_q != HT1) || (hrise && hlow_q != HSW) ||
                (vrise && vlow_q != VSW) || (vfall && vcnt_q != VT1) ||
                (bright != in_win));
    end

    always_comb begin
        h_prev_d = h_prev_q;
        v_prev_d = v_prev_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        hlow_d   = hlow_q;
        vlow_d   = vlow_q;
        good_d   = good_q;
        errcnt_d = errcnt_q;
        state_d  = state_q;
        ferr_d   = ferr_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        fdone_d  = 1'b0;
        if (pix_en) begin
            h_prev_d = hSync;
            v_prev_d = vSync;
            hcnt_d   = hcnt_nx;
            vcnt_d   = vcnt_nx;
            hlow_d   = hlow_nx;
            vlow_d   = vlow_nx;
            err_d    = viol;
            if (viol && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
            case (state_q)
                S_SEARCH: begin
                    if (vfall) begin
                        state_d = S_TRACK;
                        good_d  = '0;
                        ferr_d  = 1'b0;
                    end
                end
                S_TRACK: begin
                    if (vfall) begin
                        fdone_d = 1'b1;
                        ferr_d  = 1'b0;
                        if (ferr_q || viol) begin
                            good_d = '0;
                        end else begin
                            good_d = good_q + 8'd1;
                            if (good_q + 8'd1 == LF) begin
                                state_d  = S_LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else if (viol) begin
                        good_d = '0;
                        ferr_d = 1'b1;
                    end
                end
                S_LOCKED: begin
                    fdone_d = vfall;
                    if (viol) begin
                        state_d  = S_TRACK;
                        good_d   = '0;
                        locked_d = 1'b0;
                        // an error on the vfall itself belongs to the frame just closed
                        ferr_d   = ~vfall;
                    end else if (vfall) begin
                        ferr_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = S_SEARCH;
                    good_d   = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_prev_q <= 1'b1;
            v_prev_q <= 1'b1;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hlow_q   <= '0;
            vlow_q   <= '0;
            good_q   <= '0;
            errcnt_q <= '0;
            state_q  <= S_SEARCH;
            ferr_q   <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            h_prev_q <= h_prev_d;
            v_prev_q <= v_prev_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hlow_q   <= hlow_d;
            vlow_q   <= vlow_d;
            good_q   <= good_d;
            errcnt_q <= errcnt_d;
            state_q  <= state_d;
            ferr_q   <= ferr_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            fdone_q  <= fdone_d;
        end
    end

    assign hCount_rx  = hcnt_q;
    assign vCount_rx  = vcnt_q;
    assign locked     = locked_q;
    assign frame_done = fdone_q;
    assign err        = err_q;
    assign err_count  = errcnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down timing so whole frames fit
// in a short run; a behavioural model is compared every clock.
module tb_vga_sync_decoder;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HS  = 6;
    localparam int VS  = 2;
    localparam int HA0 = 10;
    localparam int HA  = 24;
    localparam int VA0 = 4;
    localparam int VA  = 12;
    localparam int LF  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic       hSync = 1'b1;
    logic       vSync = 1'b1;
    logic       bright = 1'b0;
    logic [9:0] hCount_rx, vCount_rx;
    logic       locked, frame_done, err;
    logic [7:0] err_count;
    logic [1:0] state;

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
        .H_ACT_START(HA0), .H_ACT(HA), .V_ACT_START(VA0), .V_ACT(VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
        .bright(bright), .hCount_rx(hCount_rx), .vCount_rx(vCount_rx),
        .locked(locked), .frame_done(frame_done), .err(err),
        .err_count(err_count), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    int gap_lo = 1;
    int gap_hi = 1;

    // model state: expected outputs plus sample-index bookkeeping
    int m_h, m_v, m_ec, m_state, m_good, m_idx, m_hf_idx;
    bit m_hp, m_vp, m_ferr, m_locked, e_err, e_fd;

    function automatic bit win(input int h, input int v);
        return h >= HA0 && h <= HA0 + HA - 1 && v >= VA0 && v <= VA0 + VA - 1;
    endfunction

    task automatic model_step(input bit r, input bit p, input bit hs,
                              input bit vs, input bit br);
        bit hf, hr, vf, vr, bad;
        int lowh, nh, nv;
        if (r) begin
            m_h = 0; m_v = 0; m_ec = 0; m_state = 0; m_good = 0;
            m_idx = 0; m_hf_idx = 0; m_hp = 1; m_vp = 1;
            m_ferr = 0; m_locked = 0; e_err = 0; e_fd = 0;
        end else if (!p) begin
            e_err = 0;
            e_fd = 0;
        end else begin
            m_idx++;
            hf = m_hp && !hs;
            hr = !m_hp && hs;
            vf = m_vp && !vs;
            vr = !m_vp && vs;
            lowh = m_idx - m_hf_idx;
            if (hf) m_hf_idx = m_idx;
            nh = m_idx - m_hf_idx;
            if (nh > 1023) nh = 1023;
            nv = vf ? 0 : (hf ? (m_v < 1023 ? m_v + 1 : 1023) : m_v);
            bad = (m_state != 0) &&
                  ((hf && m_h != HT - 1) || (hr && lowh != HS) ||
                   (vr && m_v + 1 != VS) || (vf && m_v != VT - 1) ||
                   (br != win(nh, nv)));
            e_err = bad;
            if (bad && m_ec < 255) m_ec++;
            e_fd = vf && m_state != 0;
            if (m_state == 0) begin
                if (vf) begin m_state = 1; m_good = 0; m_ferr = 0; end
            end else if (m_state == 1) begin
                if (vf) begin
                    m_good = (m_ferr || bad) ? 0 : m_good + 1;
                    m_ferr = 0;
                    if (m_good == LF) begin m_state = 2; m_locked = 1; end
                end else if (bad) begin
                    m_good = 0;
                    m_ferr = 1;
                end
            end else begin
                if (bad) begin
                    m_state = 1; m_good = 0; m_locked = 0; m_ferr = !vf;
                end else if (vf) begin
                    m_ferr = 0;
                end
            end
            m_h = nh;
            m_v = nv;
            m_hp = hs;
            m_vp = vs;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (hCount_rx !== 10'(m_h) || vCount_rx !== 10'(m_v) ||
                locked !== m_locked || frame_done !== e_fd || err !== e_err ||
                err_count !== 8'(m_ec) || state !== 2'(m_state)) begin
                errors++;
                $display("FAIL model t=%0t h %0d/%0d v %0d/%0d lk %0b/%0b fd %0b/%0b err %0b/%0b ec %0d/%0d st %0d/%0d (got/want)",
                         $time, hCount_rx, m_h, vCount_rx, m_v, locked, m_locked,
                         frame_done, e_fd, err, e_err, err_count, m_ec, state, m_state);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // drive one clock; returns just after the following falling edge
    task automatic cycle(input bit r, input bit p, input bit hs,
                         input bit vs, input bit br);
        rst = r; pix_en = p; hSync = hs; vSync = vs; bright = br;
        model_step(r, p, hs, vs, br);
        if (r) chk_on = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic smp(input bit hs, input bit vs, input bit br);
        int g;
        g = $urandom_range(gap_hi, gap_lo);
        cycle(1'b0, 1'b1, hs, vs, br);
        for (int i = 1; i < g; i++)
            cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic line(input int v, input int h0, input int len, input int hsw,
                        input bit vlow, input int f1, input int f2);
        for (int h = h0; h < len; h++)
            smp(h >= hsw, !vlow, win(h, v) ^ (h == f1 || h == f2));
    endtask

    // kind: 1 short line, 2 narrow hSync, 3 bright faults at h=2 and h=20
    task automatic frame(input int vsw, input int bad_v, input int kind);
        int len, hsw, f1, f2;
        for (int v = 0; v < VT; v++) begin
            len = HT; hsw = HS; f1 = -1; f2 = -1;
            if (v == bad_v) begin
                if (kind == 1) len = HT - 1;
                if (kind == 2) hsw = HS - 1;
                if (kind == 3) begin f1 = 2; f2 = 20; end
            end
            line(v, 0, len, hsw, v < vsw, f1, f2);
        end
    endtask

    initial begin
        @(negedge clk);
        #1;
        // clean stream, strobe every 4 clocks
        gap_lo = 4; gap_hi = 4;
        do_reset();
        lit("rst_h", hCount_rx, 0);
        lit("rst_state", state, 0);
        lit("rst_ec", err_count, 0);
        frame(VS, -1, 0);
        lit("t1_track", state, 1);
        frame(VS, -1, 0);
        lit("t1_notlocked", locked, 0);
        frame(VS, -1, 0);
        lit("t1_locked", locked, 1);
        lit("t1_state", state, 2);
        frame(VS, -1, 0);
        lit("t1_ec", err_count, 0);

        // short line while locked
        gap_lo = 1; gap_hi = 2;
        frame(VS, 5, 1);
        lit("t2_ec", err_count, 1);
        lit("t2_state", state, 1);
        lit("t2_lock0", locked, 0);
        frame(VS, -1, 0);
        frame(VS, -1, 0);
        lit("t2_still0", locked, 0);
        frame(VS, -1, 0);
        lit("t2_relock", locked, 1);

        // sync width faults
        do_reset();
        frame(VS, -1, 0);
        frame(VS, 5, 2);
        lit("t3_hsw_ec", err_count, 1);
        frame(VS + 1, -1, 0);
        lit("t3_vsw_ec", err_count, 2);

        // window faults in SEARCH, then in TRACK
        do_reset();
        for (int v = 2; v < VT; v++)
            line(v, 0, HT, HS, 1'b0, v == 8 ? 2 : -1, v == 8 ? 20 : -1);
        lit("t4_search_ec", err_count, 0);
        lit("t4_search_st", state, 0);
        frame(VS, -1, 0);
        frame(VS, 8, 3);
        lit("t4_track_ec", err_count, 2);

        // reset mid-frame with pix_en high
        do_reset();
        frame(VS, -1, 0);
        frame(VS, -1, 0);
        frame(VS, -1, 0);
        lit("t5_pre_lock", locked, 1);
        for (int v = 0; v < 10; v++) line(v, 0, HT, HS, v < VS, -1, -1);
        line(10, 0, 15, HS, 1'b0, -1, -1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, win(15, 10));
        lit("t5_h", hCount_rx, 0);
        lit("t5_v", vCount_rx, 0);
        lit("t5_lock", locked, 0);
        lit("t5_state", state, 0);
        line(10, 16, HT, HS, 1'b0, -1, -1);
        for (int v = 11; v < VT; v++) line(v, 0, HT, HS, 1'b0, -1, -1);
        frame(VS, -1, 0);
        frame(VS, -1, 0);
        lit("t5_nolock", locked, 0);
        frame(VS, -1, 0);
        lit("t5_relock", locked, 1);

        // continuous broken lines saturate the error total
        gap_lo = 1; gap_hi = 1;
        do_reset();
        for (int n = 0; n < 300; n++)
            line(n % VT, 0, HT - 2, HS, (n % VT) < VS, -1, -1);
        lit("t6_ec_sat", err_count, 255);
        lit("t6_lock", locked, 0);
        lit("t6_state", state, 1);
        for (int i = 0; i < 100; i++)
            cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        lit("t6_idle_ec", err_count, 255);
        lit("t6_idle_err", err, 0);

        // hCount saturation with no syncs
        do_reset();
        for (int i = 0; i < 1100; i++) smp(1'b1, 1'b1, 1'b0);
        lit("t7_hsat", hCount_rx, 1023);
        lit("t7_v", vCount_rx, 0);
        lit("t7_state", state, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
